// File: rtl/membus_dma_pkg.sv
// Shared membus constants, DMA copy FSM state encoding and the address alignment helper.
package membus_dma_pkg;

  localparam int unsigned MEMBUS_DATA_WIDTH = 32;
  localparam int unsigned XLEN              = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } dma_state_t;

  // Clear the byte-offset bits so the address points at the start of a bus word.
  function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                             input int unsigned bytes_per_word);
    return addr & ~(64'(bytes_per_word) - 64'd1);
  endfunction

endpackage

// File: rtl/membus_if.sv
// Membus request/response port: held valid/ready request, one rvalid per accepted request.
interface membus #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output valid, wen, addr, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, wen, addr, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/membus_dma_copy.sv
// Word-granular memory-to-memory copy engine on a single membus master port.
// Moves len_words words one at a time (read then write), holding each request until ready.
module membus_dma_copy
  import membus_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = XLEN,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
  output logic                  busy,
  output logic                  done,
  membus.master                 bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned STEP       = STRB_WIDTH;

  dma_state_t              state_q, state_n;
  logic [ADDR_WIDTH-1:0]   src_q, src_n;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_n;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0]   data_q, data_n;

  logic                    valid_q, valid_n;
  logic                    wen_q, wen_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [STRB_WIDTH-1:0]   wmask_q, wmask_n;
  logic                    busy_n, done_n;

  // Next-state, working registers and the request presented in the next state.
  always_comb begin
    state_n = state_q;
    src_n   = src_q;
    dst_n   = dst_q;
    cnt_n   = cnt_q;
    data_n  = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_words != '0) begin
            src_n   = ADDR_WIDTH'(align_addr(64'(src_addr), STEP));
            dst_n   = ADDR_WIDTH'(align_addr(64'(dst_addr), STEP));
            cnt_n   = len_words;
            state_n = RD_REQ;
          end else begin
            state_n = DONE;
          end
        end
      end
      RD_REQ:  if (bus.ready)  state_n = RD_WAIT;
      RD_WAIT: begin
        if (bus.rvalid) begin
          data_n  = bus.rdata;
          state_n = WR_REQ;
        end
      end
      WR_REQ:  if (bus.ready)  state_n = WR_WAIT;
      WR_WAIT: begin
        // Compare before decrementing so the count never underflows.
        if (bus.rvalid) begin
          src_n   = src_q + ADDR_WIDTH'(STEP);
          dst_n   = dst_q + ADDR_WIDTH'(STEP);
          cnt_n   = cnt_q - LEN_WIDTH'(1);
          state_n = (cnt_q == LEN_WIDTH'(1)) ? DONE : RD_REQ;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    valid_n = (state_n == RD_REQ) || (state_n == WR_REQ);
    wen_n   = (state_n == WR_REQ);
    addr_n  = '0;
    wdata_n = '0;
    wmask_n = '0;
    if (state_n == RD_REQ) begin
      addr_n = src_n;
    end else if (state_n == WR_REQ) begin
      addr_n  = dst_n;
      wdata_n = data_n;
      wmask_n = '1;
    end
    busy_n = (state_n != IDLE) && (state_n != DONE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      src_q   <= src_n;
      dst_q   <= dst_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      wen_q   <= wen_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      wmask_q <= wmask_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    bus.valid = valid_q;
    bus.wen   = wen_q;
    bus.addr  = addr_q;
    bus.wdata = wdata_q;
    bus.wmask = wmask_q;
  end

endmodule
